// File: rtl/vio_route_stamper_pkg.sv
// Purpose: shared widths, stamper FSM states and route config word for the vFPGA route stamper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lynxTypes;

    localparam int AXI_DATA_BITS  = 512;
    localparam int PID_BITS       = 6;
    localparam int VIO_ROUTE_BITS = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } vio_stamp_state_t;

    typedef struct packed {
        logic                      en;
        logic [VIO_ROUTE_BITS-1:0] route;
    } vio_route_cfg_t;

endpackage

// File: rtl/vio_route_stamper_skid.sv
// Purpose: 2-entry AXI4SR register slice (output register + skid register) with route as sideband.
// Latency: 1 cycle s->m when empty.
// Backpressure: s_tready = skid register empty; full rate under continuous m_tready.
// Ports: aclk/areset (sync, active-high); s_* sink with s_route sideband; m_* source with m_route.
module vio_skid_buffer #(
    parameter int DATA_BITS  = 512,
    parameter int TID_BITS   = 6,
    parameter int ROUTE_BITS = 14
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [DATA_BITS-1:0]    s_tdata,
    input  logic [DATA_BITS/8-1:0]  s_tkeep,
    input  logic                    s_tlast,
    input  logic [TID_BITS-1:0]     s_tid,
    input  logic [ROUTE_BITS-1:0]   s_route,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_BITS-1:0]    m_tdata,
    output logic [DATA_BITS/8-1:0]  m_tkeep,
    output logic                    m_tlast,
    output logic [TID_BITS-1:0]     m_tid,
    output logic [ROUTE_BITS-1:0]   m_route
);

    localparam int PW = ROUTE_BITS + TID_BITS + 1 + DATA_BITS/8 + DATA_BITS;

    logic [PW-1:0] w_in;
    logic [PW-1:0] r_out;
    logic [PW-1:0] r_skid;
    logic          r_out_vld;
    logic          r_skid_vld;
    logic          w_push;

    assign w_in     = {s_route, s_tid, s_tlast, s_tkeep, s_tdata};
    assign s_tready = ~r_skid_vld;
    assign w_push   = s_tvalid & ~r_skid_vld;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
            r_out      <= '0;
            r_skid     <= '0;
        end else if (~r_out_vld | m_tready) begin
            // Output slot frees this cycle: the older skid entry goes first.
            if (r_skid_vld) begin
                r_out      <= r_skid;
                r_out_vld  <= 1'b1;
                r_skid_vld <= 1'b0;
            end else begin
                r_out_vld <= w_push;
                if (w_push) begin
                    r_out <= w_in;
                end
            end
        end else if (w_push) begin
            // Output stalled: park the beat accepted this cycle.
            r_skid     <= w_in;
            r_skid_vld <= 1'b1;
        end
    end

    assign m_tvalid = r_out_vld;
    assign {m_route, m_tid, m_tlast, m_tkeep, m_tdata} = r_out;

endmodule

// File: rtl/vio_route_stamper.sv
// Purpose: latch a host route word, stamp it as per-packet-stable tdest, drop traffic while routing is disabled.
// Latency: 1 cycle s->m through a 2-entry skid buffer.
// Backpressure: s_tready follows skid space while forwarding; always 1 while dropping; 0 in reset.
// Ports: aclk/areset (sync, active-high); cfg_* host config; s_*/m_* AXI4SR; m_route tdest; drop_cnt/pkt_cnt.
// Optional: VIO_ROUTE_STATS_EN implements drop_cnt/pkt_cnt; without it both are tied to 0.
module vio_route_stamper
    import lynxTypes::*;
#(
    parameter int DATA_BITS  = AXI_DATA_BITS,
    parameter int TID_BITS   = PID_BITS,
    parameter int ROUTE_BITS = VIO_ROUTE_BITS
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    cfg_valid,
    input  logic [ROUTE_BITS-1:0]   cfg_route,
    input  logic                    cfg_en,
    output logic                    cfg_pending,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [DATA_BITS-1:0]    s_tdata,
    input  logic [DATA_BITS/8-1:0]  s_tkeep,
    input  logic                    s_tlast,
    input  logic [TID_BITS-1:0]     s_tid,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [DATA_BITS-1:0]    m_tdata,
    output logic [DATA_BITS/8-1:0]  m_tkeep,
    output logic                    m_tlast,
    output logic [TID_BITS-1:0]     m_tid,
    output logic [ROUTE_BITS-1:0]   m_route,
    output logic [31:0]             drop_cnt,
    output logic [31:0]             pkt_cnt
);

    vio_stamp_state_t        r_state;
    logic                    r_act_en;
    logic [ROUTE_BITS-1:0]   r_act_route;
    logic                    r_pnd_en;
    logic [ROUTE_BITS-1:0]   r_pnd_route;
    logic                    r_pnd_vld;

    logic                    w_idle;
    logic                    w_apply;
    logic                    w_eff_en;
    logic [ROUTE_BITS-1:0]   w_eff_route;
    logic                    w_fwd;
    logic                    w_acc;
    logic                    w_skid_rdy;
    logic                    w_skid_vld;
    logic                    w_drop_done;

    // A pending config takes effect only between packets; the decision beat
    // already sees the applied value so there is no bubble on a change.
    assign w_idle      = (r_state == ST_IDLE);
    assign w_apply     = w_idle & s_tvalid & r_pnd_vld & ~areset;
    assign w_eff_en    = w_apply ? r_pnd_en    : r_act_en;
    // Outside IDLE no apply can occur, so this is the route latched at the packet's first beat.
    assign w_eff_route = w_apply ? r_pnd_route : r_act_route;

    assign w_fwd       = (r_state == ST_PASS) | (w_idle & w_eff_en);
    assign s_tready    = ~areset & (w_fwd ? w_skid_rdy : 1'b1);
    assign w_acc       = s_tvalid & s_tready;
    assign w_skid_vld  = s_tvalid & w_fwd & ~areset;
    assign w_drop_done = w_acc & s_tlast & ~w_fwd;
    assign cfg_pending = r_pnd_vld;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= ST_IDLE;
            r_act_en    <= 1'b0;
            r_act_route <= '0;
            r_pnd_en    <= 1'b0;
            r_pnd_route <= '0;
            r_pnd_vld   <= 1'b0;
        end else begin
            if (w_apply) begin
                r_act_en    <= r_pnd_en;
                r_act_route <= r_pnd_route;
            end
            // A fresh write beats a same-cycle apply and keeps the pending flag up.
            if (cfg_valid) begin
                r_pnd_en    <= cfg_en;
                r_pnd_route <= cfg_route;
                r_pnd_vld   <= 1'b1;
            end else if (w_apply) begin
                r_pnd_vld   <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_acc & ~s_tlast) begin
                        r_state <= w_eff_en ? ST_PASS : ST_DROP;
                    end
                end
                ST_PASS, ST_DROP: begin
                    if (w_acc & s_tlast) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    vio_skid_buffer #(
        .DATA_BITS  (DATA_BITS),
        .TID_BITS   (TID_BITS),
        .ROUTE_BITS (ROUTE_BITS)
    ) u_skid (
        .aclk     (aclk),
        .areset   (areset),
        .s_tvalid (w_skid_vld),
        .s_tready (w_skid_rdy),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tlast  (s_tlast),
        .s_tid    (s_tid),
        .s_route  (w_eff_route),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tlast  (m_tlast),
        .m_tid    (m_tid),
        .m_route  (m_route)
    );

`ifdef VIO_ROUTE_STATS_EN
    logic [31:0] r_drop_cnt;
    logic [31:0] r_pkt_cnt;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_drop_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            if (w_drop_done) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
            if (m_tvalid & m_tready & m_tlast) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    assign drop_cnt = r_drop_cnt;
    assign pkt_cnt  = r_pkt_cnt;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_drop_done;
    assign drop_cnt = '0;
    assign pkt_cnt  = '0;
`endif

endmodule

// File: tb/tb_vio_route_stamper.sv
// Purpose: randomized and directed checking of vio_route_stamper against a packet-level reference model.
// Latency: expects 1 cycle s->m with an empty skid buffer.
// Backpressure: random and constant m_tready; dropped packets must never stall the sink.
module tb_vio_route_stamper;
    import lynxTypes::*;

    localparam int DB = 64;
    localparam int KB = DB / 8;
    localparam int TB = 4;
    localparam int RB = 14;
`ifdef VIO_ROUTE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [RB-1:0] route;
        logic [TB-1:0] tid;
        logic          last;
        logic [KB-1:0] keep;
        logic [DB-1:0] data;
    } beat_t;

    logic          aclk = 1'b0;
    logic          areset;
    logic          cfg_valid;
    logic [RB-1:0] cfg_route;
    logic          cfg_en;
    logic          cfg_pending;
    logic          s_tvalid;
    logic          s_tready;
    logic [DB-1:0] s_tdata;
    logic [KB-1:0] s_tkeep;
    logic          s_tlast;
    logic [TB-1:0] s_tid;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [DB-1:0] m_tdata;
    logic [KB-1:0] m_tkeep;
    logic          m_tlast;
    logic [TB-1:0] m_tid;
    logic [RB-1:0] m_route;
    logic [31:0]   drop_cnt;
    logic [31:0]   pkt_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rdy_mode = 0;

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    always @(posedge aclk) begin
        #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
    end

    vio_route_stamper #(.DATA_BITS(DB), .TID_BITS(TB), .ROUTE_BITS(RB)) dut (
        .aclk(aclk), .areset(areset),
        .cfg_valid(cfg_valid), .cfg_route(cfg_route), .cfg_en(cfg_en), .cfg_pending(cfg_pending),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
        .s_tlast(s_tlast), .s_tid(s_tid),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tlast(m_tlast), .m_tid(m_tid), .m_route(m_route),
        .drop_cnt(drop_cnt), .pkt_cnt(pkt_cnt)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- reference model (packet level) ----------------
    beat_t         exp_q[$];
    logic [RB-1:0] obs_route[$];
    int            obs_cyc[$];
    bit            md_act_en, md_pnd_en, md_pnd_vld, md_in_pkt, md_fwd;
    logic [RB-1:0] md_act_route, md_pnd_route, md_route;
    int unsigned   md_drop, md_pkt;
    bit            prev_stall;
    beat_t         prev_beat;

    always @(negedge aclk) begin
        beat_t got;
        beat_t e;
        bit    fwd_now;
        got = {m_route, m_tid, m_tlast, m_tkeep, m_tdata};

        chk("cfg_pending", 128'(cfg_pending), 128'(md_pnd_vld));
        chk("drop_cnt", 128'(drop_cnt), STATS ? 128'(md_drop) : 128'd0);
        chk("pkt_cnt", 128'(pkt_cnt), STATS ? 128'(md_pkt) : 128'd0);

        if (prev_stall) begin
            chk("hold_tvalid", 128'(m_tvalid), 128'd1);
            chk("hold_payload", 128'(got), 128'(prev_beat));
        end

        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_beat", 128'(got), 128'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_beat", 128'(got), 128'(e));
                obs_route.push_back(m_route);
                obs_cyc.push_back(cyc);
                if (m_tlast) md_pkt++;
            end
        end
        prev_stall = m_tvalid && !m_tready && !areset;
        prev_beat  = got;

        if (areset) begin
            exp_q.delete();
            md_act_en = 0; md_act_route = '0; md_pnd_vld = 0;
            md_in_pkt = 0; md_drop = 0; md_pkt = 0;
            prev_stall = 0;
        end else begin
            if (s_tvalid && !md_in_pkt && md_pnd_vld) begin
                md_act_en = md_pnd_en; md_act_route = md_pnd_route; md_pnd_vld = 0;
            end
            if (s_tvalid) begin
                fwd_now = md_in_pkt ? md_fwd : md_act_en;
                if (!fwd_now) chk("drop_tready", 128'(s_tready), 128'd1);
                if (s_tready) begin
                    if (!md_in_pkt) begin
                        md_fwd = md_act_en; md_route = md_act_route;
                    end
                    if (md_fwd) exp_q.push_back({md_route, s_tid, s_tlast, s_tkeep, s_tdata});
                    else if (s_tlast) md_drop++;
                    md_in_pkt = !s_tlast;
                end
            end
            if (cfg_valid) begin
                md_pnd_en = cfg_en; md_pnd_route = cfg_route; md_pnd_vld = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    task automatic do_cfg(input logic [RB-1:0] r, input logic en);
        cfg_valid = 1'b1; cfg_route = r; cfg_en = en;
        @(posedge aclk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send_pkt(input int nb, input bit with_last, input int cfg_beat,
                            input logic [RB-1:0] c_route, input logic c_en, input int gap,
                            output int stalls, output int acc_cyc0);
        stalls = 0; acc_cyc0 = -1;
        for (int i = 0; i < nb; i++) begin
            bit acc;
            int guard;
            s_tvalid = 1'b1;
            s_tdata  = {$urandom(), $urandom()};
            s_tkeep  = KB'($urandom());
            s_tid    = TB'($urandom());
            s_tlast  = with_last && (i == nb - 1);
            if (i == cfg_beat) begin
                cfg_valid = 1'b1; cfg_route = c_route; cfg_en = c_en;
            end
            acc = 0; guard = 0;
            while (!acc) begin
                @(negedge aclk);
                acc = s_tready;
                if (acc && i == 0) acc_cyc0 = cyc;
                @(posedge aclk); #1;
                cfg_valid = 1'b0;
                if (!acc) begin
                    stalls++; guard++;
                    if (guard > 200) begin
                        chk("s_tready_timeout", 128'd0, 128'd1);
                        acc = 1;
                    end
                end
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        idle(gap);
    endtask

    initial begin
        int st, c0, base, tot;
        areset = 1'b1; cfg_valid = 1'b0; cfg_route = '0; cfg_en = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tid = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_s_tready", 128'(s_tready), 128'd0);
        chk("rst_m_tvalid", 128'(m_tvalid), 128'd0);
        chk("rst_m_route", 128'(m_route), 128'd0);
        chk("rst_m_payload", 128'({m_tdata, m_tkeep, m_tlast, m_tid}), 128'd0);
        chk("rst_cfg_pending", 128'(cfg_pending), 128'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        idle(2);

        // No config: 4-beat packet is swallowed without stalling.
        send_pkt(4, 1, -1, '0, 1'b0, 3, st, c0);
        chk("t1_stalls", 128'(st), 128'd0);
        chk("t1_no_output", 128'(obs_route.size()), 128'd0);
        chk("t1_drop_cnt", 128'(drop_cnt), STATS ? 128'd1 : 128'd0);

        // Route 0x0028: 3 beats out, 1-cycle latency, full rate.
        do_cfg(14'h0028, 1'b1);
        base = obs_route.size();
        send_pkt(3, 1, -1, '0, 1'b0, 4, st, c0);
        chk("t2_stalls", 128'(st), 128'd0);
        chk("t2_beats", 128'(obs_route.size() - base), 128'd3);
        for (int i = 0; i < 3; i++) chk("t2_route", 128'(obs_route[base+i]), 128'h0028);
        chk("t2_latency", 128'(obs_cyc[base] - c0), 128'd1);
        chk("t2_pkt_cnt", 128'(pkt_cnt), STATS ? 128'd1 : 128'd0);

        // Config change mid-packet only affects the next packet.
        base = obs_route.size();
        send_pkt(5, 1, 1, 14'h0018, 1'b1, 3, st, c0);
        chk("t3_pending_held", 128'(cfg_pending), 128'd1);
        send_pkt(2, 1, -1, '0, 1'b0, 3, st, c0);
        chk("t3_pending_clear", 128'(cfg_pending), 128'd0);
        chk("t3_beats", 128'(obs_route.size() - base), 128'd7);
        for (int i = 0; i < 5; i++) chk("t3_old_route", 128'(obs_route[base+i]), 128'h0028);
        for (int i = 5; i < 7; i++) chk("t3_new_route", 128'(obs_route[base+i]), 128'h0018);

        // Back-to-back 1-beat packets under random backpressure.
        rdy_mode = 1;
        base = obs_route.size();
        for (int i = 0; i < 60; i++) send_pkt(1, 1, -1, '0, 1'b0, 0, st, c0);
        rdy_mode = 0;
        idle(6);
        chk("t4_no_loss", 128'(obs_route.size() - base), 128'd60);
        chk("t4_queue_empty", 128'(exp_q.size()), 128'd0);

        // Full rate with m_tready held high.
        base = obs_route.size(); tot = 0;
        for (int i = 0; i < 8; i++) begin
            send_pkt(1, 1, -1, '0, 1'b0, 0, st, c0);
            tot += st;
        end
        idle(4);
        chk("t4_full_rate_stalls", 128'(tot), 128'd0);
        chk("t4_full_rate_span", 128'(obs_cyc[base+7] - obs_cyc[base]), 128'd7);

        // Disable mid-packet: this packet completes, the next one drops.
        base = obs_route.size();
        send_pkt(4, 1, 1, 14'h0003, 1'b0, 3, st, c0);
        chk("t5_completed", 128'(obs_route.size() - base), 128'd4);
        for (int i = 0; i < 4; i++) chk("t5_route", 128'(obs_route[base+i]), 128'h0018);
        send_pkt(3, 1, -1, '0, 1'b0, 3, st, c0);
        chk("t5_dropped", 128'(obs_route.size() - base), 128'd4);
        chk("t5_drop_stalls", 128'(st), 128'd0);

        // Reset on beat 2 of 4, then traffic drops until reconfigured.
        do_cfg(14'h002A, 1'b1);
        send_pkt(1, 0, -1, '0, 1'b0, 0, st, c0);
        s_tvalid = 1'b1; s_tdata = {$urandom(), $urandom()}; areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0; s_tvalid = 1'b0;
        @(negedge aclk);
        chk("t6_m_tvalid", 128'(m_tvalid), 128'd0);
        chk("t6_m_route", 128'(m_route), 128'd0);
        chk("t6_m_payload", 128'({m_tdata, m_tkeep, m_tlast, m_tid}), 128'd0);
        chk("t6_cfg_pending", 128'(cfg_pending), 128'd0);
        @(posedge aclk); #1;
        base = obs_route.size();
        send_pkt(4, 1, -1, '0, 1'b0, 3, st, c0);
        chk("t6_post_rst_dropped", 128'(obs_route.size() - base), 128'd0);
        chk("t6_drop_cnt", 128'(drop_cnt), STATS ? 128'd1 : 128'd0);

        idle(4);
        chk("end_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
